pkt_rx_loopback: RTL and testbench

//  Far-end consumer of the xge_mac packet-receive interface. Reads frames with the
//  pkt_rx_avail/pkt_rx_ren handshake and stores them in a store-and-forward buffer.

---
 rtl/pkt_lb_pkg.sv | 11 +
 rtl/pkt_lb_buf.sv | 21 ++
 rtl/pkt_rx_loopback.sv | 137 +++++++++++++
 tb/tb_pkt_rx_loopback.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_lb_pkg.sv
// pkt_lb_pkg: shared types and constants for the packet-receive loopback
package pkt_lb_pkg;
    typedef enum logic {R_IDLE, R_READ} rx_state_e;
    typedef enum logic {T_IDLE, T_SEND} tx_state_e;
    typedef struct packed {
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } buf_entry_t;
    localparam logic [2:0] MOD_FULL = 3'd0;
endpackage

// File: rtl/pkt_lb_buf.sv
// pkt_lb_buf: simple dual-port frame buffer with one write port and a registered read port
module pkt_lb_buf
    import pkt_lb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  buf_entry_t    wd,
    input  logic [AW-1:0] ra,
    output buf_entry_t    rd
);
    buf_entry_t mem [DEPTH];
    // write port plus registered read; the read address is re-sampled every cycle
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/pkt_rx_loopback.sv
// pkt_rx_loopback: store-and-forward loopback from the MAC rx interface to its tx interface
module pkt_rx_loopback
    import pkt_lb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 32
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25_n,
    input  logic                     pkt_rx_avail,
    output logic                     pkt_rx_ren,
    input  logic                     pkt_rx_val,
    input  logic [63:0]              pkt_rx_data,
    input  logic                     pkt_rx_sop,
    input  logic                     pkt_rx_eop,
    input  logic [2:0]               pkt_rx_mod,
    input  logic                     pkt_rx_err,
    input  logic                     pkt_tx_full,
    output logic                     pkt_tx_val,
    output logic [63:0]              pkt_tx_data,
    output logic                     pkt_tx_sop,
    output logic                     pkt_tx_eop,
    output logic [2:0]               pkt_tx_mod,
    output logic [CNT_W-1:0]         stat_frames_ok,
    output logic [CNT_W-1:0]         stat_frames_err,
    output logic [CNT_W-1:0]         stat_frames_ovf,
    output logic [$clog2(DEPTH):0]   buf_words_used
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    FULL_X = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CMAX   = '1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? CMAX : s[CNT_W-1:0];
    endfunction

    rx_state_e     rx_state, rx_next;
    tx_state_e     tx_state, tx_next;
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, rd_nxt, pending, base;
    logic          drop, in_frame, full_q, tx_first;
    logic          rx_v, trunc, dr, fb, we, commit, issue, tx_done;
    logic [AW-1:0] ra;
    buf_entry_t    wd, rd;

    assign buf_words_used = wr_ptr - rd_ptr;

    pkt_lb_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk (clk_156m25),
        .we  (we),
        .wa  (base[AW-1:0]),
        .wd  (wd),
        .ra  (ra),
        .rd  (rd)
    );

    // rx handshake and per-word write decision; a truncating sop restarts from the commit point
    always_comb begin
        rx_v       = (rx_state == R_READ) && pkt_rx_val;
        pkt_rx_ren = (rx_state == R_READ) && !(pkt_rx_val && pkt_rx_eop);
        rx_next    = (rx_state == R_IDLE) ? (pkt_rx_avail ? R_READ : R_IDLE)
                                          : ((rx_v && pkt_rx_eop) ? R_IDLE : R_READ);
        trunc      = rx_v && pkt_rx_sop && in_frame;
        base       = trunc ? wr_commit : wr_ptr;
        dr         = drop && !trunc;
        fb         = (base ^ rd_ptr) == FULL_X;
        we         = rx_v && !(pkt_rx_eop && pkt_rx_err) && !dr && !fb;
        commit     = we && pkt_rx_eop;
        wd         = '{eop: pkt_rx_eop, mod: pkt_rx_eop ? pkt_rx_mod : MOD_FULL, data: pkt_rx_data};
    end

    // rx state, write pointers, drop tracking and statistics
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            rx_state        <= R_IDLE;
            wr_ptr          <= '0;
            wr_commit       <= '0;
            drop            <= 1'b0;
            in_frame        <= 1'b0;
            stat_frames_ok  <= '0;
            stat_frames_err <= '0;
            stat_frames_ovf <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_v) begin
                wr_ptr          <= we ? base + 1'b1 : (pkt_rx_eop ? wr_commit : base);
                drop            <= !pkt_rx_eop && (dr || fb);
                in_frame        <= !pkt_rx_eop;
                if (commit) wr_commit <= base + 1'b1;
                stat_frames_ok  <= sat_add(stat_frames_ok, {1'b0, commit});
                stat_frames_err <= sat_add(stat_frames_err, 2'(trunc) + 2'(pkt_rx_eop && pkt_rx_err));
                stat_frames_ovf <= sat_add(stat_frames_ovf, {1'b0, pkt_rx_eop && !pkt_rx_err && (dr || fb)});
            end
        end
    end

    // tx issue decision; the read address runs one word ahead so rd always holds the entry at rd_ptr
    always_comb begin
        issue   = (tx_state == T_SEND) && !full_q;
        tx_done = issue && rd.eop;
        tx_next = (tx_state == T_IDLE) ? ((pending != '0 && !pkt_tx_full) ? T_SEND : T_IDLE)
                                       : (tx_done ? T_IDLE : T_SEND);
        rd_nxt  = rd_ptr + PW'(issue);
        ra      = rd_nxt[AW-1:0];
    end

    // tx state, read pointer, pending-frame count and registered tx outputs
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            tx_state    <= T_IDLE;
            rd_ptr      <= '0;
            pending     <= '0;
            full_q      <= 1'b0;
            tx_first    <= 1'b1;
            pkt_tx_val  <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
        end else begin
            tx_state   <= tx_next;
            rd_ptr     <= rd_nxt;
            full_q     <= pkt_tx_full;
            pending    <= pending + PW'(commit) - PW'(tx_done);
            pkt_tx_val <= issue;
            if (issue) begin
                pkt_tx_data <= rd.data;
                pkt_tx_sop  <= tx_first;
                pkt_tx_eop  <= rd.eop;
                pkt_tx_mod  <= rd.mod;
                tx_first    <= rd.eop;
            end
        end
    end
endmodule

// File: tb/tb_pkt_rx_loopback.sv
// tb_pkt_rx_loopback: directed bench with a MAC rx model and a tx capture queue
module tb_pkt_rx_loopback;
    localparam int CW = 2;

    logic          clk_156m25 = 1'b0;
    logic          reset_156m25_n = 1'b0;
    logic          pkt_rx_avail = 1'b0;
    logic          pkt_rx_ren;
    logic          pkt_rx_val = 1'b0;
    logic [63:0]   pkt_rx_data = '0;
    logic          pkt_rx_sop = 1'b0;
    logic          pkt_rx_eop = 1'b0;
    logic [2:0]    pkt_rx_mod = '0;
    logic          pkt_rx_err = 1'b0;
    logic          pkt_tx_full = 1'b0;
    logic          pkt_tx_val;
    logic [63:0]   pkt_tx_data;
    logic          pkt_tx_sop;
    logic          pkt_tx_eop;
    logic [2:0]    pkt_tx_mod;
    logic [CW-1:0] stat_frames_ok;
    logic [CW-1:0] stat_frames_err;
    logic [CW-1:0] stat_frames_ovf;
    logic [8:0]    buf_words_used;

    pkt_rx_loopback #(.DEPTH(256), .CNT_W(CW)) dut (
        .clk_156m25      (clk_156m25),
        .reset_156m25_n  (reset_156m25_n),
        .pkt_rx_avail    (pkt_rx_avail),
        .pkt_rx_ren      (pkt_rx_ren),
        .pkt_rx_val      (pkt_rx_val),
        .pkt_rx_data     (pkt_rx_data),
        .pkt_rx_sop      (pkt_rx_sop),
        .pkt_rx_eop      (pkt_rx_eop),
        .pkt_rx_mod      (pkt_rx_mod),
        .pkt_rx_err      (pkt_rx_err),
        .pkt_tx_full     (pkt_tx_full),
        .pkt_tx_val      (pkt_tx_val),
        .pkt_tx_data     (pkt_tx_data),
        .pkt_tx_sop      (pkt_tx_sop),
        .pkt_tx_eop      (pkt_tx_eop),
        .pkt_tx_mod      (pkt_tx_mod),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_err (stat_frames_err),
        .stat_frames_ovf (stat_frames_ovf),
        .buf_words_used  (buf_words_used)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [63:0] data;
    } mac_w_t;

    mac_w_t      mac_q[$];
    logic [68:0] tx_q[$];
    logic        ren_s = 1'b0;
    int          total = 0;
    int          bad = 0;

    initial forever #5 clk_156m25 = ~clk_156m25;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // sample ren and the tx interface away from the active edge
    initial forever begin
        @(negedge clk_156m25);
        ren_s = pkt_rx_ren;
        if (reset_156m25_n && pkt_tx_val)
            tx_q.push_back({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data});
    end

    // MAC rx model: one word per accepted ren, data one cycle after ren
    initial begin
        mac_w_t w;
        forever begin
            @(posedge clk_156m25);
            #1;
            if (!reset_156m25_n) begin
                mac_q.delete();
                pkt_rx_val = 1'b0;
            end else if (ren_s && mac_q.size() > 0) begin
                w = mac_q.pop_front();
                pkt_rx_val  = 1'b1;
                pkt_rx_data = w.data;
                pkt_rx_sop  = w.sop;
                pkt_rx_eop  = w.eop;
                pkt_rx_mod  = w.mod;
                pkt_rx_err  = w.err;
            end else begin
                pkt_rx_val = 1'b0;
                pkt_rx_sop = 1'b0;
                pkt_rx_eop = 1'b0;
                pkt_rx_err = 1'b0;
            end
            pkt_rx_avail = mac_q.size() > 0;
        end
    end

    function automatic logic [63:0] wdat(int f, int i);
        return {8'(f), 8'h5A, 16'(i), 16'hC0DE, 16'(i ^ 'h77)};
    endfunction

    task automatic chk(string tag, logic [68:0] obs, logic [68:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(int f, int n, logic [2:0] m, logic e, logic has_eop);
        for (int i = 0; i < n; i++) begin
            mac_w_t w;
            w.sop  = (i == 0);
            w.eop  = has_eop && (i == n - 1);
            w.err  = w.eop && e;
            w.mod  = m;
            w.data = wdat(f, i);
            mac_q.push_back(w);
        end
    endtask

    task automatic wait_tx(int n, int budget, string tag);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin
            @(negedge clk_156m25);
            c++;
        end
        chk({tag, "_tx_timeout"}, 69'(tx_q.size() >= n), 69'(1));
    endtask

    task automatic wait_drain(int budget);
        int c = 0;
        while (mac_q.size() > 0 && c < budget) begin
            @(negedge clk_156m25);
            c++;
        end
        chk("rx_drain_timeout", 69'(mac_q.size()), 69'(0));
    endtask

    task automatic expect_frame(int f, int n, logic [2:0] m, string tag);
        for (int i = 0; i < n; i++) begin
            logic [68:0] got;
            got = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
            chk($sformatf("%s_w%0d", tag, i), got,
                {(i == 0), (i == n - 1), ((i == n - 1) ? m : 3'd0), wdat(f, i)});
        end
    endtask

    initial begin
        // reset state with no traffic
        repeat (3) @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        repeat (2) @(negedge clk_156m25);
        chk("rst_ren", 69'(pkt_rx_ren), 69'(0));
        chk("rst_tx_val", 69'(pkt_tx_val), 69'(0));
        chk("rst_ok", 69'(stat_frames_ok), 69'(0));
        chk("rst_err", 69'(stat_frames_err), 69'(0));
        chk("rst_ovf", 69'(stat_frames_ovf), 69'(0));
        chk("rst_used", 69'(buf_words_used), 69'(0));

        // one good 64B frame
        send(1, 8, 3'd0, 1'b0, 1'b1);
        wait_tx(8, 200, "t2");
        expect_frame(1, 8, 3'd0, "t2");
        repeat (5) @(negedge clk_156m25);
        chk("t2_extra", 69'(tx_q.size()), 69'(0));
        chk("t2_ok", 69'(stat_frames_ok), 69'(1));
        chk("t2_used", 69'(buf_words_used), 69'(0));

        // errored 61B frame then a good 64B frame
        send(2, 8, 3'd5, 1'b1, 1'b1);
        send(3, 8, 3'd0, 1'b0, 1'b1);
        wait_tx(8, 300, "t3");
        repeat (20) @(negedge clk_156m25);
        chk("t3_count", 69'(tx_q.size()), 69'(8));
        expect_frame(3, 8, 3'd0, "t3");
        chk("t3_err", 69'(stat_frames_err), 69'(1));
        chk("t3_ok", 69'(stat_frames_ok), 69'(2));

        // tx blocked: 200-word frame fits, 100-word frame overflows
        pkt_tx_full = 1'b1;
        send(4, 200, 3'd6, 1'b0, 1'b1);
        send(5, 100, 3'd2, 1'b0, 1'b1);
        wait_drain(1000);
        repeat (5) @(negedge clk_156m25);
        chk("t4_ovf", 69'(stat_frames_ovf), 69'(1));
        chk("t4_used", 69'(buf_words_used), 69'(200));
        chk("t4_ok", 69'(stat_frames_ok), 69'(3));
        chk("t4_blocked", 69'(tx_q.size()), 69'(0));
        pkt_tx_full = 1'b0;
        wait_tx(200, 1000, "t4");
        expect_frame(4, 200, 3'd6, "t4");
        repeat (10) @(negedge clk_156m25);
        chk("t4_extra", 69'(tx_q.size()), 69'(0));
        chk("t4_used_end", 69'(buf_words_used), 69'(0));

        // truncated frame, then a good frame; ok counter saturates at 3
        send(6, 4, 3'd0, 1'b0, 1'b0);
        send(7, 5, 3'd3, 1'b0, 1'b1);
        wait_tx(5, 300, "t5");
        repeat (10) @(negedge clk_156m25);
        chk("t5_count", 69'(tx_q.size()), 69'(5));
        expect_frame(7, 5, 3'd3, "t5");
        chk("t5_err", 69'(stat_frames_err), 69'(2));
        chk("t5_ok_sat", 69'(stat_frames_ok), 69'(3));
        chk("t5_used", 69'(buf_words_used), 69'(0));

        // reset in the middle of a frame, then a fresh frame
        send(8, 10, 3'd0, 1'b0, 1'b1);
        repeat (6) @(negedge clk_156m25);
        reset_156m25_n = 1'b0;
        repeat (2) @(negedge clk_156m25);
        chk("t6_no_partial", 69'(tx_q.size()), 69'(0));
        reset_156m25_n = 1'b1;
        @(negedge clk_156m25);
        chk("t6_rst_ok", 69'(stat_frames_ok), 69'(0));
        chk("t6_rst_err", 69'(stat_frames_err), 69'(0));
        chk("t6_rst_used", 69'(buf_words_used), 69'(0));
        chk("t6_rst_tx_val", 69'(pkt_tx_val), 69'(0));
        send(9, 6, 3'd1, 1'b0, 1'b1);
        wait_tx(6, 300, "t6");
        repeat (10) @(negedge clk_156m25);
        chk("t6_count", 69'(tx_q.size()), 69'(6));
        expect_frame(9, 6, 3'd1, "t6");
        chk("t6_ok", 69'(stat_frames_ok), 69'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
